// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, requester ids
// and a width helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WDATA = 2'd2;
  localparam logic [1:0] ST_RDATA = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    WDATA = ST_WDATA,
    RDATA = ST_RDATA
  } state_t;

  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way winner select. Round-robin by default; MEM_ARB_DCACHE_PRIO_EN makes
// the dcache win every tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_served,
  output logic       winner
);

`ifdef MEM_ARB_DCACHE_PRIO_EN
  logic unused_last_served;
  assign unused_last_served = last_served;

  always_comb begin
    winner = REQ_ICACHE;
    if (req_valid[1]) begin
      winner = REQ_DCACHE;
    end
  end
`else
  // On a tie the requester that did not go last wins.
  always_comb begin
    winner = REQ_ICACHE;
    case (req_valid)
      2'b10:   winner = REQ_DCACHE;
      2'b11:   winner = ~last_served;
      default: winner = REQ_ICACHE;
    endcase
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between icache (id 0) and dcache (id 1),
// holding the grant for a full BEATS-beat line transfer. Option: MEM_ARB_DCACHE_PRIO_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_rw,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [1:0]          wdata_valid,
  output logic [1:0]          wdata_ready,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          resp_valid,
  output logic [DATA_W-1:0]   resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_wdata_valid,
  input  logic                mem_wdata_ready,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy,
  output logic                grant_id
);

  localparam int CNT_W = (clog2(BEATS) < 1) ? 1 : clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_t             state_q, state_d;
  logic               grant_q;
  logic               rw_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_served_q;
  logic               pick;
  logic               pick_rw;
  logic [ADDR_W-1:0]  pick_addr;
  logic               beat_hs;
  logic               last_hs;

  mem_arb_pick u_pick (
    .req_valid   (req_valid),
    .last_served (last_served_q),
    .winner      (pick)
  );

  assign pick_rw   = pick ? req_rw[1] : req_rw[0];
  assign pick_addr = pick ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign last_hs   = beat_hs && (cnt_q == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= REQ_ICACHE;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      cnt_q         <= '0;
      last_served_q <= REQ_DCACHE;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |req_valid) begin
        grant_q <= pick;
        rw_q    <= pick_rw;
        addr_q  <= pick_addr;
      end
      // The counter only moves on data handshakes and clears on the final one.
      if (beat_hs) begin
        if (last_hs) begin
          cnt_q         <= '0;
          last_served_q <= grant_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    req_ready       = 2'b00;
    wdata_ready     = 2'b00;
    resp_valid      = 2'b00;
    mem_req_valid   = 1'b0;
    mem_wdata_valid = 1'b0;
    beat_hs         = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        req_ready     = grant_q ? {mem_req_ready, 1'b0} : {1'b0, mem_req_ready};
        if (mem_req_ready) begin
          state_d = rw_q ? WDATA : RDATA;
        end
      end
      WDATA: begin
        mem_wdata_valid = grant_q ? wdata_valid[1] : wdata_valid[0];
        wdata_ready     = grant_q ? {mem_wdata_ready, 1'b0} : {1'b0, mem_wdata_ready};
        beat_hs         = mem_wdata_valid && mem_wdata_ready;
        if (last_hs) begin
          state_d = IDLE;
        end
      end
      RDATA: begin
        resp_valid = grant_q ? {mem_resp_valid, 1'b0} : {1'b0, mem_resp_valid};
        beat_hs    = mem_resp_valid;
        if (last_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_rw   = rw_q;
  assign mem_req_addr = addr_q;
  assign mem_wdata    = grant_q ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  assign resp_data    = mem_resp_data;
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing-memory port between the icache miss path (requester 0) and the dcache miss/writeback path (requester 1).
- Arbitrates between the two requesters, forwards the chosen request, and streams BEATS data beats in either direction.
- Holds the grant until the last beat of the transaction completes.
- Sits between the cache controllers and the memory model, below the datapath's stall logic.

Parameters:
- ADDR_W, 28: line-granular memory address width.
- DATA_W, 128: width of one data beat.
- BEATS, 4: beats per line transfer; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  request valid per requester; bit 0 = icache, bit 1 = dcache.
- req_ready  out  2  request accepted by memory this cycle.
- req_rw  in  2  per-requester direction; 1 = write, 0 = read.
- req_addr  in  2*ADDR_W  per-requester address; requester n uses bits [n*ADDR_W +: ADDR_W].
- wdata_valid  in  2  write beat valid per requester.
- wdata_ready  out  2  write beat consumed.
- wdata  in  2*DATA_W  per-requester write beat.
- resp_valid  out  2  read beat valid for that requester.
- resp_data  out  DATA_W  read beat, shared by both requesters.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_rw  out  1  direction of the request to memory.
- mem_req_addr  out  ADDR_W  address of the request to memory.
- mem_wdata_valid  out  1  write beat to memory valid.
- mem_wdata_ready  in  1  memory consumes the write beat.
- mem_wdata  out  DATA_W  write beat to memory.
- mem_resp_valid  in  1  read beat from memory valid.
- mem_resp_data  in  DATA_W  read beat from memory.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  1  id of the current owner; meaningful only while busy.

Behaviour:
- States: IDLE, REQ, WDATA, RDATA. Reset takes effect at any point, including mid-transaction:
  - state = IDLE, beat counter = 0, last_served = 1 (so icache wins the first tie), grant_id = 0;
  - all valid/ready outputs = 0; data outputs are don't-care.
- IDLE:
  - If any req_valid bit is set, pick a winner g and latch g, req_rw[g] and req_addr[g].
  - Next state REQ; IDLE->REQ takes exactly one cycle.
  - Default arbitration is round-robin: when both are valid, the winner is the requester that is not last_served.
- REQ:
  - mem_req_valid = 1, with mem_req_addr and mem_req_rw driven from the latched values.
  - req_ready[g] = mem_req_ready (combinational); the other req_ready bit is 0.
  - On the handshake, go to WDATA if the latched rw = 1, else RDATA.
  - Requesters must hold req_valid, req_rw and req_addr stable until req_ready. Withdrawal is illegal, and the latched request is issued regardless.
- WDATA:
  - mem_wdata_valid = wdata_valid[g], mem_wdata = wdata of g, wdata_ready[g] = mem_wdata_ready.
  - Beat counter increments on each handshake.
  - On the handshake with counter = BEATS-1: counter clears, last_served = g, state goes to IDLE.
- RDATA:
  - resp_valid[g] = mem_resp_valid and resp_data = mem_resp_data, with no added latency and no backpressure.
  - The termination rule is the same as WDATA.
- Outside RDATA, mem_resp_valid is ignored. Outside WDATA, wdata_valid is ignored and wdata_ready = 0.
- The losing requester sees no ready/valid activity until the grant is released.
- Back-to-back: a new arbitration starts in the IDLE cycle after the last beat. Minimum gap between transactions is one idle cycle.
- Beat counter width is clog2(BEATS), minimum 1 bit. It never wraps past BEATS-1.

Optional Feature:
- Macro: MEM_ARB_DCACHE_PRIO_EN.
- Defined: fixed priority; dcache (bit 1) always wins ties, and last_served is still updated but not used.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding localparams (IDLE/REQ/WDATA/RDATA);
  - requester ids REQ_ICACHE = 0 and REQ_DCACHE = 1;
  - a clog2 helper function.
- Sub-module mem_arb_pick: combinational 2-way winner select from req_valid and last_served, with the priority macro applied there.

Test Plan:
- Reset, then only req_valid = 01 with a read at addr 0x100 → grant_id = 0; mem_req_valid high one cycle after the request; 4 resp beats 0xA..0xD appear on resp_valid[0] only; busy drops after beat 4.
- Both valid on the first cycle after reset, both reads → icache served first, dcache next; repeated simultaneous requests alternate 0,1,0,1.
- dcache write at addr 0x2A0 with a 2-cycle mem_wdata_ready gap on beat 3 → exactly 4 mem_wdata handshakes with data in order; wdata_ready[1] tracks mem_wdata_ready.
- mem_req_ready held low for 5 cycles in REQ → mem_req_valid and mem_req_addr stay stable, req_ready = 00, state unchanged.
- reset asserted after beat 2 of a read → next cycle busy = 0 and all valids = 0; a fresh request then completes a full 4 beats.
- MEM_ARB_DCACHE_PRIO_EN defined, both valid for 3 consecutive transactions → dcache is granted all 3 times.
